// File: rtl/prio_fifo_pkg.sv
// prio_fifo_pkg
// Shared sizing constants and the index-entry type for the priority FIFO.
//   DATA_W      : width of a stored entry (key in the MSBs, payload below)
//   KEY_W       : width of the priority key
//   DEPTH       : number of entries the FIFO can hold (power of two)
//   ADDR_W      : log2(DEPTH), width of a RAM slot address
//   idx_entry_t : one element of the ordered index list, {key, slot}
package prio_fifo_pkg;

  localparam int DATA_W = 16;
  localparam int KEY_W  = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [KEY_W-1:0]  key;
    logic [ADDR_W-1:0] slot;
  } idx_entry_t;

endpackage

// File: rtl/prio_index_list.sv
// prio_index_list
// Sorted list of (key, slot) pairs. Position 0 always holds the entry that
// pops next. A new pair is placed after every stored pair whose key is <= its
// own key, which keeps equal keys in arrival order. Insert and pop may happen
// in the same cycle; the pop is applied first so the new pair never competes
// for the head.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   push      : insert ins_entry this cycle
//   pop       : remove the head entry this cycle
//   ins_entry : pair to insert
//   cnt       : number of valid pairs currently stored (owned by the caller)
//   head_slot : RAM slot of the head pair
module prio_index_list
  import prio_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  idx_entry_t        ins_entry,
  input  logic [ADDR_W:0]   cnt,
  output logic [ADDR_W-1:0] head_slot
);

  idx_entry_t      list_q [DEPTH];
  idx_entry_t      list_d [DEPTH];
  idx_entry_t      base   [DEPTH];
  logic [DEPTH-1:0] le;
  logic [ADDR_W:0]  base_cnt;

  // List contents after the pop, before the insert.
  assign base_cnt = cnt - (ADDR_W+1)'(pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == DEPTH - 1) begin : g_last
        assign base[gi] = pop ? idx_entry_t'('0) : list_q[gi];
      end else begin : g_mid
        assign base[gi] = pop ? list_q[gi+1] : list_q[gi];
      end

      // le is a prefix of ones because the list is sorted: it marks the
      // valid entries that stay ahead of the new pair.
      assign le[gi] = ((ADDR_W+1)'(gi) < base_cnt) && (base[gi].key <= ins_entry.key);

      // The first position whose le is 0 takes the new pair; everything
      // behind it shifts down by one.
      if (gi == 0) begin : g_first
        assign list_d[gi] = (!push || le[gi]) ? base[gi] : ins_entry;
      end else begin : g_rest
        assign list_d[gi] = (!push || le[gi]) ? base[gi] :
                            le[gi-1]          ? ins_entry : base[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) list_q[i] <= '0;
    end else begin
      list_q <= list_d;
    end
  end

  assign head_slot = list_q[0].slot;

endmodule

// File: rtl/prio_fifo_ram.sv
// prio_fifo_ram
// Priority FIFO that pops the smallest key first (ties in arrival order).
// Entries live in a DEPTH x DATA_W RAM addressed by slot. A circular free
// list hands out slots for writes and takes back slots freed by pops. The
// pop order is kept by prio_index_list.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   we, din  : write request and entry (din[15:8] = key, din[7:0] = payload)
//   re       : read request
//   dout     : entry popped by the last accepted read (holds otherwise)
//   valid    : one-cycle pulse after each accepted read
//   empty    : no entries stored
//   full     : DEPTH entries stored
module prio_fifo_ram
  import prio_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] ram [DEPTH];

  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              valid_q;
  logic [DATA_W-1:0] dout_q;

  logic [ADDR_W-1:0] free_q [DEPTH];
  logic [ADDR_W-1:0] free_d [DEPTH];
  logic [ADDR_W-1:0] fhead_q, fhead_d;
  logic [ADDR_W-1:0] ftail_q, ftail_d;

  logic              rd_ok, wr_ok;
  logic [ADDR_W-1:0] head_slot;
  logic [ADDR_W-1:0] wr_slot;
  idx_entry_t        ins_entry;

  assign rd_ok = re && !empty_q && !rst;
  // A full FIFO still accepts a write when a read frees a slot this edge.
  assign wr_ok = we && (!full_q || rd_ok) && !rst;

  // On a simultaneous read and write the slot being popped is handed straight
  // to the new entry, so the free list is untouched. The RAM is read-first,
  // so the popped data is still returned.
  assign wr_slot   = rd_ok ? head_slot : free_q[fhead_q];
  assign ins_entry = {din[DATA_W-1 -: KEY_W], wr_slot};

  prio_index_list u_index (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_ok),
    .pop       (rd_ok),
    .ins_entry (ins_entry),
    .cnt       (count_q),
    .head_slot (head_slot)
  );

  always_comb begin
    count_d = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
    empty_d = (count_d == '0);
    full_d  = (count_d == (ADDR_W+1)'(DEPTH));

    free_d  = free_q;
    fhead_d = fhead_q;
    ftail_d = ftail_q;
    if (wr_ok && !rd_ok) fhead_d = fhead_q + 1'b1;
    if (rd_ok && !wr_ok) begin
      free_d[ftail_q] = head_slot;
      ftail_d         = ftail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      fhead_q <= '0;
      ftail_q <= '0;
      for (int i = 0; i < DEPTH; i++) free_q[i] <= ADDR_W'(i);
    end else begin
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      valid_q <= rd_ok;
      fhead_q <= fhead_d;
      ftail_q <= ftail_d;
      free_q  <= free_d;
    end
  end

  // Payload RAM: no reset, registered read.
  always_ff @(posedge clk) begin
    if (wr_ok) ram[wr_slot] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst)        dout_q <= '0;
    else if (rd_ok) dout_q <= ram[head_slot];
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: tb/tb_prio_fifo_ram.sv
// tb_prio_fifo_ram
// Directed stimulus with a queue-based reference model (pop = earliest entry
// among those with the smallest key). Outputs are compared with the model on
// every falling edge; directed steps also check hand-computed values.
module tb_prio_fifo_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic        re  = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        valid, empty, full;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  prio_fifo_ram dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .din   (din),
    .re    (re),
    .dout  (dout),
    .valid (valid),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  // Reference model.
  logic [15:0] mq[$];
  logic [15:0] m_dout  = '0;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_dout  = '0;
      m_valid = 1'b0;
    end else begin
      bit rd, wr;
      rd = re && (mq.size() != 0);
      wr = we && ((mq.size() < 32) || rd);
      m_valid = rd;
      if (rd) begin
        int idx;
        idx = 0;
        for (int i = 1; i < mq.size(); i++)
          if (mq[i][15:8] < mq[idx][15:8]) idx = i;
        m_dout = mq[idx];
        mq.delete(idx);
      end
      if (wr) mq.push_back(din);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", 32'(valid), 32'(m_valid));
      check("cyc_dout",  32'(dout),  32'(m_dout));
      check("cyc_empty", 32'(empty), 32'(mq.size() == 0));
      check("cyc_full",  32'(full),  32'(mq.size() == 32));
    end
  end

  task automatic step(input logic w, input logic [15:0] d, input logic r);
    @(negedge clk);
    we = w; din = d; re = r;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; we = 1'b1; re = 1'b1; din = 16'h0101;
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] exp27 [3];
    exp27[0] = 16'h1002; exp27[1] = 16'h3003; exp27[2] = 16'h5001;

    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dout",  32'(dout),  32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Three keys out of order, read back sorted.
    step(1, 16'h5001, 0);
    step(1, 16'h1002, 0);
    step(1, 16'h3003, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0, 1);
      check("sort3_dout",  32'(dout),  32'(exp27[i]));
      check("sort3_valid", 32'(valid), 32'd1);
    end
    check("sort3_empty", 32'(empty), 32'd1);
    step(0, 16'h0, 0);
    check("sort3_pulse", 32'(valid), 32'd0);

    // Equal keys pop in arrival order; read right after the write.
    step(1, 16'h2001, 0);
    step(1, 16'h2002, 0);
    step(0, 16'h0, 1);
    check("tie_first",  32'(dout), 32'h2001);
    step(0, 16'h0, 1);
    check("tie_second", 32'(dout), 32'h2002);

    // Fill to 32 with duplicate keys, drop a 33rd write, drain sorted.
    for (int i = 0; i < 32; i++) step(1, {8'((i * 5) % 12 * 16), 8'(i)}, 0);
    check("fill_full", 32'(full), 32'd1);
    step(1, 16'h0000, 0);
    check("drop_full", 32'(full), 32'd1);
    prev = '0;
    for (int i = 0; i < 32; i++) begin
      step(0, 16'h0, 1);
      check("drain_valid", 32'(valid), 32'd1);
      if (i > 0)
        check("drain_order", 32'((prev[15:8] < dout[15:8]) ||
                                 (prev[15:8] == dout[15:8] && prev[7:0] < dout[7:0])), 32'd1);
      prev = dout;
    end
    check("drain_empty", 32'(empty), 32'd1);
    step(0, 16'h0, 1);
    check("read_empty_valid", 32'(valid), 32'd0);
    check("read_empty_hold",  32'(dout),  32'(prev));

    // 31 entries, min key 0x04; simultaneous read+write of a smaller key.
    for (int i = 0; i < 31; i++) step(1, {8'(4 + i), 8'(i)}, 0);
    step(1, 16'h0300, 1);
    check("rw_dout",  32'(dout),  32'h0400);
    check("rw_empty", 32'(empty), 32'd0);
    check("rw_full",  32'(full),  32'd0);
    step(1, 16'h7F00, 0);
    check("rw_count31", 32'(full), 32'd1);
    // Full: read and write both happen, stays full.
    step(1, 16'h0201, 1);
    check("full_rw_dout", 32'(dout), 32'h0300);
    check("full_rw_full", 32'(full), 32'd1);
    step(0, 16'h0, 1);
    check("full_rw_next", 32'(dout), 32'h0201);
    for (int i = 0; i < 31; i++) step(0, 16'h0, 1);
    check("drain2_empty", 32'(empty), 32'd1);

    // Read+write while empty: only the write happens.
    step(1, 16'h4455, 1);
    check("erw_valid", 32'(valid), 32'd0);
    check("erw_empty", 32'(empty), 32'd0);
    step(0, 16'h0, 1);
    check("erw_read", 32'(dout), 32'h4455);

    // Reset mid-operation with requests asserted.
    for (int i = 0; i < 5; i++) step(1, {8'(9 - i), 8'(i)}, 0);
    do_reset();
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_full",  32'(full),  32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_dout",  32'(dout),  32'd0);
    step(0, 16'h0, 1);
    check("post_rst_read", 32'(valid), 32'd0);
    step(1, 16'h0A0B, 0);
    step(0, 16'h0, 1);
    check("post_rst_rw", 32'(dout), 32'h0A0B);

    step(0, 16'h0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
